// File: rtl/rq_converter_mw_if.sv
// Stream bundle shared by the request side and the RQ side.
// Widths are chosen per instance.
interface rq_converter_mw_if #(
   parameter int DATA_W = 256,
   parameter int KEEP_W = DATA_W/32,
   parameter int USER_W = 128
);
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic [USER_W-1:0] tuser;

   modport master (
      output tvalid, tlast, tdata, tkeep, tuser,
      input  tready
   );

   modport slave (
      input  tvalid, tlast, tdata, tkeep, tuser,
      output tready
   );
endinterface

// File: rtl/rq_converter_mw.sv
// Request stream to RQ converter: inserts a 128-bit header and
// realigns the payload by 4 DW, with a skid input and registered output.
module rq_converter_mw #(
   parameter int         DATA_W  = 256,
   parameter int         KEEP_W  = DATA_W/32,
   parameter int         TUSER_W = 128,
   parameter logic [2:0] RQ_ATTR = 3'd0,
   parameter logic [2:0] RQ_TC   = 3'd0
) (
   input  logic              dma_clk,
   input  logic              rst,
   rq_converter_mw_if.slave  axis_req,
   rq_converter_mw_if.master s_axis_rq,
   input  logic [15:0]       req_id_in,
   output logic [31:0]       pkt_cnt
);
   localparam int LO_W = DATA_W - 128;
   localparam int LO_K = KEEP_W - 4;

   typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

   typedef struct packed {
      logic [3:0]  req_type;
      logic [7:0]  tag;
      logic [61:0] addr;
      logic [10:0] dw_cnt;
      logic [3:0]  first_be;
      logic [3:0]  last_be;
   } desc_t;

   state_t            state;
   logic              in_rdy;
   logic              skid_v;
   logic [DATA_W-1:0] skid_data;
   logic [KEEP_W-1:0] skid_keep;
   logic              skid_last;
   desc_t             skid_desc;
   logic [127:0]      carry_data;
   logic [3:0]        carry_keep;
   logic [3:0]        seq_num;
   logic [15:0]       req_id_q;

   logic              o_valid;
   logic              o_last;
   logic [DATA_W-1:0] o_data;
   logic [KEEP_W-1:0] o_keep;
   logic [59:0]       o_user;

   desc_t             in_desc;
   desc_t             cur_desc;
   logic [DATA_W-1:0] cur_data;
   logic [KEEP_W-1:0] cur_keep;
   logic              cur_last;
   logic              in_hs;
   logic              cur_v;
   logic              out_free;
   logic              adv;
   logic              tail_go;
   logic              need_tail;
   logic              first;
   logic              skid_nxt;
   logic              rdy_nxt;
   logic [127:0]      hdr;
   logic [59:0]       first_user;
   logic              unused_tuser;

   assign unused_tuser = ^{axis_req.tuser[TUSER_W-1:108],
                           axis_req.tuser[33:19]};

   assign in_desc = {axis_req.tuser[107:104],
                     axis_req.tuser[103:96],
                     axis_req.tuser[95:34],
                     axis_req.tuser[18:8],
                     axis_req.tuser[7:4],
                     axis_req.tuser[3:0]};

   assign cur_data = skid_v ? skid_data : axis_req.tdata;
   assign cur_keep = skid_v ? skid_keep : axis_req.tkeep;
   assign cur_last = skid_v ? skid_last : axis_req.tlast;
   assign cur_desc = skid_v ? skid_desc : in_desc;

   assign in_hs     = axis_req.tvalid & in_rdy;
   assign cur_v     = skid_v | in_hs;
   assign out_free  = ~o_valid | s_axis_rq.tready;
   assign adv       = cur_v & (state != TAIL) & out_free;
   assign tail_go   = (state == TAIL) & out_free;
   assign need_tail = |cur_keep[KEEP_W-1:LO_K];
   assign first     = (state == IDLE);

   // Skid holds a beat only when the output stage could not take it.
   assign skid_nxt = skid_v ? ~adv : (in_hs & ~adv);
   assign rdy_nxt  = ~skid_nxt
                   & ~(adv & cur_last & need_tail)
                   & ~((state == TAIL) & ~tail_go);

   always_comb begin
      hdr            = '0;
      hdr[63:2]      = cur_desc.addr;
      hdr[74:64]     = cur_desc.dw_cnt;
      hdr[78:75]     = cur_desc.req_type;
      hdr[95:80]     = req_id_q;
      hdr[103:96]    = cur_desc.tag;
      hdr[123:121]   = RQ_TC;
      hdr[126:124]   = RQ_ATTR;
   end

   always_comb begin
      first_user        = '0;
      first_user[3:0]   = cur_desc.first_be;
      first_user[7:4]   = cur_desc.last_be;
      first_user[27:24] = seq_num;
   end

   assign axis_req.tready  = in_rdy;
   assign s_axis_rq.tvalid = o_valid;
   assign s_axis_rq.tlast  = o_last;
   assign s_axis_rq.tdata  = o_data;
   assign s_axis_rq.tkeep  = o_keep;
   assign s_axis_rq.tuser  = o_user;

   always_ff @(posedge dma_clk) begin
      if (rst) begin
         state      <= IDLE;
         in_rdy     <= 1'b0;
         skid_v     <= 1'b0;
         skid_data  <= '0;
         skid_keep  <= '0;
         skid_last  <= 1'b0;
         skid_desc  <= '0;
         carry_data <= '0;
         carry_keep <= '0;
         seq_num    <= '0;
         req_id_q   <= '0;
         pkt_cnt    <= '0;
         o_valid    <= 1'b0;
         o_last     <= 1'b0;
         o_data     <= '0;
         o_keep     <= '0;
         o_user     <= '0;
      end else begin
         req_id_q <= req_id_in;
         in_rdy   <= rdy_nxt;
         skid_v   <= skid_nxt;
         if (~skid_v & in_hs & ~adv) begin
            skid_data <= axis_req.tdata;
            skid_keep <= axis_req.tkeep;
            skid_last <= axis_req.tlast;
            skid_desc <= in_desc;
         end
         if (o_valid & s_axis_rq.tready & o_last)
            pkt_cnt <= pkt_cnt + 32'd1;
         if (out_free)
            o_valid <= 1'b0;
         unique case (1'b1)
            adv: begin
               carry_data <= cur_data[DATA_W-1:LO_W];
               carry_keep <= cur_keep[KEEP_W-1:LO_K];
               o_valid    <= 1'b1;
               o_last     <= cur_last & ~need_tail;
               o_data     <= {cur_data[LO_W-1:0],
                              first ? hdr : carry_data};
               o_keep     <= {cur_keep[LO_K-1:0],
                              first ? 4'hF : carry_keep};
               o_user     <= first ? first_user : '0;
               if (first)
                  seq_num <= seq_num + 4'd1;
               state <= cur_last ? (need_tail ? TAIL : IDLE)
                                 : BODY;
            end
            tail_go: begin
               o_valid <= 1'b1;
               o_last  <= 1'b1;
               o_data  <= {{LO_W{1'b0}}, carry_data};
               o_keep  <= {{LO_K{1'b0}}, carry_keep};
               o_user  <= '0;
               state   <= IDLE;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rq_converter_mw.sv
// Bench for rq_converter_mw: DW-stream reference model feeding a
// scoreboard, plus directed 256-bit and 512-bit scenarios.
module tb_rq_converter_mw;
   typedef struct {
      logic [255:0] data;
      logic [7:0]   keep;
      logic         last;
      logic [59:0]  user;
   } beat_t;

   logic        dma_clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req_id_in = 16'hBEEF;
   logic [31:0] pkt_cnt;
   logic [31:0] pkt_cnt_w;
   int          checks = 0;
   int          errors = 0;
   int          stall_cyc = 0;
   logic [3:0]  seq_m = '0;
   bit          stall_en = 1'b0;
   bit          rdy_hold = 1'b1;
   beat_t       exp_q[$];

   always #5 dma_clk = ~dma_clk;

   rq_converter_mw_if #(.DATA_W(256), .KEEP_W(8),  .USER_W(128)) req_n ();
   rq_converter_mw_if #(.DATA_W(256), .KEEP_W(8),  .USER_W(60))  rq_n ();
   rq_converter_mw_if #(.DATA_W(512), .KEEP_W(16), .USER_W(128)) req_w ();
   rq_converter_mw_if #(.DATA_W(512), .KEEP_W(16), .USER_W(60))  rq_w ();

   rq_converter_mw #(.DATA_W(256)) dut (
      .dma_clk   (dma_clk),
      .rst       (rst),
      .axis_req  (req_n),
      .s_axis_rq (rq_n),
      .req_id_in (req_id_in),
      .pkt_cnt   (pkt_cnt)
   );

   rq_converter_mw #(.DATA_W(512)) dut_w (
      .dma_clk   (dma_clk),
      .rst       (rst),
      .axis_req  (req_w),
      .s_axis_rq (rq_w),
      .req_id_in (req_id_in),
      .pkt_cnt   (pkt_cnt_w)
   );

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // output ready: held or randomly stalled
   initial begin
      rq_n.tready = 1'b1;
      rq_w.tready = 1'b1;
      forever begin
         @(posedge dma_clk);
         #1;
         rq_n.tready = stall_en ? ($urandom_range(0, 3) != 0) : rdy_hold;
      end
   end

   // scoreboard monitor and stall-stability check
   logic [255:0] p_data;
   logic [7:0]   p_keep;
   logic         p_last;
   logic [59:0]  p_user;
   bit           prev_stall = 1'b0;
   bit           prev_rst = 1'b1;
   beat_t        e;
   logic [255:0] mask;

   initial forever begin
      @(negedge dma_clk);
      if (prev_stall && !prev_rst) begin
         checks++;
         if (rq_n.tvalid !== 1'b1 || rq_n.tdata !== p_data ||
             rq_n.tkeep !== p_keep || rq_n.tlast !== p_last ||
             rq_n.tuser !== p_user) begin
            errors++;
            $display("FAIL stall_hold keep=%h last=%b required keep=%h last=%b",
                     rq_n.tkeep, rq_n.tlast, p_keep, p_last);
         end
      end
      prev_stall = rq_n.tvalid && !rq_n.tready;
      prev_rst   = rst;
      p_data     = rq_n.tdata;
      p_keep     = rq_n.tkeep;
      p_last     = rq_n.tlast;
      p_user     = rq_n.tuser;
      if (!rst && rq_n.tvalid === 1'b1 && rq_n.tready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rq_beat unexpected keep=%h required none", rq_n.tkeep);
         end else begin
            e = exp_q.pop_front();
            mask = '0;
            for (int j = 0; j < 8; j++)
               if (e.keep[j]) mask[j*32 +: 32] = '1;
            if ((rq_n.tdata & mask) !== (e.data & mask) ||
                rq_n.tkeep !== e.keep || rq_n.tlast !== e.last ||
                rq_n.tuser !== e.user) begin
               errors++;
               $display("FAIL rq_beat data=%h keep=%h last=%b user=%h required data=%h keep=%h last=%b user=%h",
                        rq_n.tdata & mask, rq_n.tkeep, rq_n.tlast, rq_n.tuser,
                        e.data & mask, e.keep, e.last, e.user);
            end
         end
      end
   end

   task automatic drive_beat(input logic [255:0] d, input logic [7:0] k,
                             input logic [127:0] u, input logic l);
      int wt = 0;
      req_n.tvalid = 1'b1;
      req_n.tdata  = d;
      req_n.tkeep  = k;
      req_n.tuser  = u;
      req_n.tlast  = l;
      @(negedge dma_clk);
      while (req_n.tready !== 1'b1 && wt < 500) begin
         wt++;
         stall_cyc++;
         @(negedge dma_clk);
      end
      if (wt >= 500) begin
         checks++;
         errors++;
         $display("FAIL req_handshake ready=%b required=1", req_n.tready);
      end
      @(posedge dma_clk);
      #1;
   endtask

   task automatic send_pkt(input int n, input logic [7:0] tag,
                           input logic [63:0] addr);
      logic [3:0]   rt, fbe, lbe;
      logic [10:0]  cnt;
      logic [127:0] hdr, u, junk;
      logic [255:0] d;
      logic [7:0]   k;
      logic [31:0]  dws[$];
      beat_t        b;
      int           nb;
      rt  = 4'($urandom);
      fbe = 4'($urandom);
      lbe = 4'($urandom);
      cnt = 11'(n);
      hdr = '0;
      hdr[63:2]   = addr[63:2];
      hdr[74:64]  = cnt;
      hdr[78:75]  = rt;
      hdr[95:80]  = req_id_in;
      hdr[103:96] = tag;
      for (int i = 0; i < 4; i++) dws.push_back(hdr[i*32 +: 32]);
      for (int i = 0; i < n; i++) dws.push_back($urandom);
      for (int s = 0; s < dws.size(); s += 8) begin
         b.data = '0;
         b.keep = '0;
         for (int j = 0; j < 8 && s + j < dws.size(); j++) begin
            b.data[j*32 +: 32] = dws[s+j];
            b.keep[j] = 1'b1;
         end
         b.last = (s + 8 >= dws.size());
         b.user = '0;
         if (s == 0) begin
            b.user[3:0]   = fbe;
            b.user[7:4]   = lbe;
            b.user[27:24] = seq_m;
         end
         exp_q.push_back(b);
      end
      seq_m++;
      u = '0;
      u[107:104] = rt;
      u[103:96]  = tag;
      u[95:32]   = addr;
      u[18:8]    = cnt;
      u[7:4]     = fbe;
      u[3:0]     = lbe;
      nb = (n == 0) ? 1 : (n + 7) / 8;
      for (int bi = 0; bi < nb; bi++) begin
         k = '0;
         for (int j = 0; j < 8; j++) begin
            d[j*32 +: 32] = $urandom;
            if (bi * 8 + j < n) begin
               d[j*32 +: 32] = dws[4 + bi*8 + j];
               k[j] = 1'b1;
            end
         end
         junk = {$urandom, $urandom, $urandom, $urandom};
         drive_beat(d, k, (bi == 0) ? u : junk, bi == nb - 1);
      end
      req_n.tvalid = 1'b0;
   endtask

   task automatic drain();
      int wt = 0;
      while (exp_q.size() != 0 && wt < 3000) begin
         @(posedge dma_clk);
         wt++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      repeat (2) @(posedge dma_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_n.tvalid = 1'b0;
      req_w.tvalid = 1'b0;
      repeat (2) @(posedge dma_clk);
      #1;
      exp_q.delete();
      seq_m = '0;
      rst = 1'b0;
      @(posedge dma_clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge dma_clk);
      @(negedge dma_clk);
      checks++;
      if (rq_n.tvalid !== 1'b0 || rq_n.tlast !== 1'b0 || rq_n.tdata !== '0 ||
          rq_n.tkeep !== '0 || rq_n.tuser !== '0) begin
         errors++;
         $display("FAIL reset_outputs valid=%b keep=%h required valid=0 keep=0",
                  rq_n.tvalid, rq_n.tkeep);
      end
      checks++;
      if (req_n.tready !== 1'b0 || pkt_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_ready_cnt ready=%b cnt=%0d required 0 0",
                  req_n.tready, pkt_cnt);
      end
      @(posedge dma_clk);
      #1;
      rst = 1'b0;
      @(posedge dma_clk);
      @(negedge dma_clk);
      checks++;
      if (req_n.tready !== 1'b1 || req_w.tready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset ready=%b/%b required=1",
                  req_n.tready, req_w.tready);
      end
      @(posedge dma_clk);
      #1;
   endtask

   task automatic test_single();
      send_pkt(4, 8'h5A, 64'h1000);
      checks++;
      if (rq_n.tvalid !== 1'b1 || rq_n.tkeep !== 8'hFF || rq_n.tlast !== 1'b1) begin
         errors++;
         $display("FAIL single_first valid=%b keep=%h last=%b required 1 ff 1",
                  rq_n.tvalid, rq_n.tkeep, rq_n.tlast);
      end
      checks++;
      if (rq_n.tdata[74:64] !== 11'd4 || rq_n.tdata[103:96] !== 8'h5A ||
          rq_n.tdata[63:0] !== 64'h1000 || rq_n.tuser[27:24] !== 4'd0) begin
         errors++;
         $display("FAIL single_header hdr=%h seq=%0d required dw=4 tag=5a addr=1000 seq=0",
                  rq_n.tdata[127:0], rq_n.tuser[27:24]);
      end
      drain();
   endtask

   task automatic test_tail();
      send_pkt(8, 8'h11, 64'h0000_0001_0000_2000);
      checks++;
      if (req_n.tready !== 1'b0) begin
         errors++;
         $display("FAIL tail_ready ready=%b required=0", req_n.tready);
      end
      drain();
   endtask

   task automatic test_read();
      send_pkt(0, 8'h22, 64'hFFFF_0000_1234_5678);
      send_pkt(0, 8'h23, 64'h40);
      drain();
   endtask

   task automatic test_back_to_back();
      stall_cyc = 0;
      send_pkt(12, 8'h31, 64'h100);
      send_pkt(20, 8'h32, 64'h200);
      send_pkt(3, 8'h33, 64'h300);
      send_pkt(0, 8'h34, 64'h400);
      send_pkt(1, 8'h35, 64'h500);
      send_pkt(28, 8'h36, 64'h600);
      checks++;
      if (stall_cyc != 0) begin
         errors++;
         $display("FAIL back_to_back stalls=%0d required=0", stall_cyc);
      end
      drain();
   endtask

   task automatic test_wide();
      logic [511:0] d0, d1, o0, o1;
      logic [15:0]  k0, k1;
      logic         l0, l1, v0, v1, v2;
      logic [127:0] u;
      logic [31:0]  src, got;
      int           bad = 0;
      int           wt = 0;
      for (int j = 0; j < 16; j++) begin
         d0[j*32 +: 32] = $urandom;
         d1[j*32 +: 32] = $urandom;
      end
      u = '0;
      u[103:96] = 8'h77;
      u[95:32]  = 64'h2000_0040;
      u[18:8]   = 11'd20;
      req_w.tdata  = d0;
      req_w.tkeep  = 16'hFFFF;
      req_w.tuser  = u;
      req_w.tlast  = 1'b0;
      req_w.tvalid = 1'b1;
      @(negedge dma_clk);
      while (req_w.tready !== 1'b1 && wt < 100) begin
         wt++;
         @(negedge dma_clk);
      end
      @(posedge dma_clk);
      #1;
      req_w.tdata = d1;
      req_w.tkeep = 16'h000F;
      req_w.tuser = '0;
      req_w.tlast = 1'b1;
      v0 = rq_w.tvalid; o0 = rq_w.tdata; k0 = rq_w.tkeep; l0 = rq_w.tlast;
      @(negedge dma_clk);
      while (req_w.tready !== 1'b1 && wt < 100) begin
         wt++;
         @(negedge dma_clk);
      end
      @(posedge dma_clk);
      #1;
      req_w.tvalid = 1'b0;
      v1 = rq_w.tvalid; o1 = rq_w.tdata; k1 = rq_w.tkeep; l1 = rq_w.tlast;
      @(posedge dma_clk);
      #1;
      v2 = rq_w.tvalid;
      checks++;
      if (wt >= 100 || v0 !== 1'b1 || k0 !== 16'hFFFF || l0 !== 1'b0) begin
         errors++;
         $display("FAIL wide_beat0 valid=%b keep=%h last=%b required 1 ffff 0", v0, k0, l0);
      end
      checks++;
      if (v1 !== 1'b1 || k1 !== 16'h00FF || l1 !== 1'b1 || v2 !== 1'b0) begin
         errors++;
         $display("FAIL wide_beat1 valid=%b keep=%h last=%b extra=%b required 1 00ff 1 0",
                  v1, k1, l1, v2);
      end
      for (int i = 0; i < 20; i++) begin
         src = (i < 16) ? d0[i*32 +: 32] : d1[(i-16)*32 +: 32];
         got = (i + 4 < 16) ? o0[(i+4)*32 +: 32] : o1[(i-12)*32 +: 32];
         if (got !== src) bad++;
      end
      checks++;
      if (bad != 0 || o0[103:96] !== 8'h77 || o0[74:64] !== 11'd20) begin
         errors++;
         $display("FAIL wide_order bad_dw=%0d tag=%h dw=%0d required 0 77 20",
                  bad, o0[103:96], o0[74:64]);
      end
      @(posedge dma_clk);
      #1;
   endtask

   task automatic test_random();
      do_reset();
      stall_en = 1'b1;
      for (int p = 0; p < 100; p++)
         send_pkt($urandom_range(0, 40), 8'($urandom),
                  {$urandom, $urandom});
      drain();
      stall_en = 1'b0;
      repeat (2) @(posedge dma_clk);
      #1;
      checks++;
      if (pkt_cnt !== 32'd100) begin
         errors++;
         $display("FAIL random_pkt_cnt cnt=%0d required=100", pkt_cnt);
      end
      send_pkt(2, 8'h44, 64'h8000);
      checks++;
      if (rq_n.tvalid !== 1'b1 || rq_n.tuser[27:24] !== 4'd4) begin
         errors++;
         $display("FAIL random_seq seq=%0d required=4", rq_n.tuser[27:24]);
      end
      drain();
   endtask

   task automatic test_midreset();
      logic [127:0] u;
      logic [255:0] d;
      rdy_hold = 1'b0;
      repeat (2) @(posedge dma_clk);
      #1;
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      u = '0;
      u[103:96] = 8'h99;
      u[18:8]   = 11'd24;
      drive_beat(d, 8'hFF, u, 1'b0);
      drive_beat(~d, 8'hFF, '0, 1'b0);
      req_n.tlast = 1'b1;
      rst = 1'b1;
      @(posedge dma_clk);
      @(negedge dma_clk);
      checks++;
      if (rq_n.tvalid !== 1'b0 || rq_n.tlast !== 1'b0 || rq_n.tdata !== '0 ||
          rq_n.tkeep !== '0 || rq_n.tuser !== '0) begin
         errors++;
         $display("FAIL midreset_outputs valid=%b keep=%h required valid=0 keep=0",
                  rq_n.tvalid, rq_n.tkeep);
      end
      checks++;
      if (req_n.tready !== 1'b0 || pkt_cnt !== 32'd0) begin
         errors++;
         $display("FAIL midreset_ready_cnt ready=%b cnt=%0d required 0 0",
                  req_n.tready, pkt_cnt);
      end
      @(posedge dma_clk);
      #1;
      req_n.tvalid = 1'b0;
      exp_q.delete();
      seq_m = '0;
      rdy_hold = 1'b1;
      rst = 1'b0;
      repeat (2) @(posedge dma_clk);
      #1;
      send_pkt(5, 8'hC3, 64'h0000_00AB_CDEF_0010);
      checks++;
      if (rq_n.tvalid !== 1'b1 || rq_n.tuser[27:24] !== 4'd0 ||
          rq_n.tdata[103:96] !== 8'hC3) begin
         errors++;
         $display("FAIL midreset_next seq=%0d tag=%h required 0 c3",
                  rq_n.tuser[27:24], rq_n.tdata[103:96]);
      end
      drain();
   endtask

   initial begin
      req_n.tvalid = 1'b0;
      req_n.tlast  = 1'b0;
      req_n.tdata  = '0;
      req_n.tkeep  = '0;
      req_n.tuser  = '0;
      req_w.tvalid = 1'b0;
      req_w.tlast  = 1'b0;
      req_w.tdata  = '0;
      req_w.tkeep  = '0;
      req_w.tuser  = '0;
      test_reset();
      test_single();
      test_tail();
      test_read();
      test_back_to_back();
      test_wide();
      test_random();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
